edgevec_sched: RTL and testbench

EDGEVEC_SCHED -- requirements
Module: edgevec_sched

---
 rtl/edgevec_sched.sv | 198 +++++++++++++++++++
 tb/tb_edgevec_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edgevec_sched.sv
// -----------------------------------------------------------------------------
// edgevec_sched
//
// Purpose:
//   Watches NLANES level signals for rising edges. Each rising edge marks the
//   lane as pending. While enable is high, one pending lane is serviced per
//   clock in round-robin order. Servicing a lane increments its wrapping
//   CNT_W-bit event counter and emits a registered one-hot grant.
//   A rising edge on a lane that is already pending, and is not being serviced
//   on that edge, is lost. It sets that lane's sticky drop flag.
//
// Parameters:
//   NLANES      number of level-signal lanes (default 2)
//   CNT_W       width of each per-lane event counter (default 2)
//
// Ports:
//   clk         single clock, all state changes on its rising edge
//   reset       synchronous active-high reset, highest priority
//   lane_vec    [NLANES]        per-lane level inputs
//   enable      grants permitted while high
//   count       [NLANES*CNT_W]  per-lane counters, lane i at [i*CNT_W +: CNT_W]
//   grant_oh    [NLANES]        registered one-hot, lane serviced on last grant
//   grant_valid registered, high for one cycle per service
//   drop        [NLANES]        sticky per-lane "event lost" flags
//   drop_total  [8]             saturating total of dropped events
//
// Configuration:
//   EDGEVEC_SCHED_DROPCNT_EN   when defined, drop_total counts dropped events
//                              and saturates at 255. When undefined,
//                              drop_total is tied to zero and the counter is
//                              not built. The drop flags behave the same in
//                              both builds.
// -----------------------------------------------------------------------------
module edgevec_sched #(
    parameter int NLANES = 2,
    parameter int CNT_W  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NLANES-1:0]         lane_vec,
    input  logic                      enable,
    output logic [NLANES*CNT_W-1:0]   count,
    output logic [NLANES-1:0]         grant_oh,
    output logic                      grant_valid,
    output logic [NLANES-1:0]         drop,
    output logic [7:0]                drop_total
);

    localparam int PTR_W = (NLANES > 1) ? $clog2(NLANES) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NLANES-1:0] prev_q;          // lane_vec from the previous edge
    logic [NLANES-1:0] pending_q;       // event seen, not yet serviced
    logic [PTR_W-1:0]  ptr_q;           // highest-priority lane this cycle
    logic [CNT_W-1:0]  count_q [NLANES];
    logic [NLANES-1:0] grant_oh_q;
    logic              grant_valid_q;
    logic [NLANES-1:0] drop_q;

    // ------------------------------------------------------------------
    // Edge detection and round-robin selection
    // ------------------------------------------------------------------
    logic [NLANES-1:0] event_vec;
    logic              sel_valid;
    logic [PTR_W-1:0]  sel_idx;
    logic [NLANES-1:0] sel_oh;
    logic [PTR_W-1:0]  ptr_next;
    logic [NLANES-1:0] pending_next;
    logic [NLANES-1:0] drop_new;

    assign event_vec = lane_vec & ~prev_q;

    // Scan from the lowest-priority offset down to offset 0 (ptr_q itself).
    // The last match written wins, so the pending lane nearest to ptr_q is
    // selected.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = NLANES - 1; k >= 0; k--) begin
            if (enable && pending_q[(int'(ptr_q) + k) % NLANES]) begin
                sel_valid = 1'b1;
                sel_idx   = PTR_W'((int'(ptr_q) + k) % NLANES);
            end
        end
    end

    always_comb begin
        sel_oh = '0;
        if (sel_valid) begin
            sel_oh[sel_idx] = 1'b1;
        end
    end

    // The lane after the one just granted becomes the highest priority.
    always_comb begin
        if (int'(sel_idx) == NLANES - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = sel_idx + PTR_W'(1);
        end
    end

    // A new event on the lane being serviced keeps that lane pending and is
    // not a loss. The service consumes the old event and the new one takes
    // its place.
    assign pending_next = (pending_q & ~sel_oh) | event_vec;
    assign drop_new     = event_vec & pending_q & ~sel_oh;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments only, so every
        // read in this block sees the value from before the edge.
        if (reset) begin
            // prev is loaded from the live input, so a lane held high across
            // reset release does not look like a rising edge.
            prev_q        <= lane_vec;
            pending_q     <= '0;
            ptr_q         <= '0;
            grant_oh_q    <= '0;
            grant_valid_q <= 1'b0;
            drop_q        <= '0;
            // NOTE: the counter array is small and visible on a port, so every
            // entry is reset. A large storage array would normally be left
            // unreset.
            for (int i = 0; i < NLANES; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            prev_q        <= lane_vec;
            pending_q     <= pending_next;
            drop_q        <= drop_q | drop_new;
            grant_valid_q <= sel_valid;
            // With no selection (idle or enable low), the grant, the pointer
            // and the counters all hold their values.
            if (sel_valid) begin
                grant_oh_q       <= sel_oh;
                ptr_q            <= ptr_next;
                count_q[sel_idx] <= count_q[sel_idx] + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NLANES; g++) begin : g_count_pack
        assign count[g*CNT_W +: CNT_W] = count_q[g];
    end

    assign grant_oh    = grant_oh_q;
    assign grant_valid = grant_valid_q;
    assign drop        = drop_q;

`ifdef EDGEVEC_SCHED_DROPCNT_EN
    // Total of lost events. Several lanes can drop on the same edge, so the
    // increment is a population count. The total is widened before the
    // saturation check so it cannot wrap.
    logic [7:0]  drop_total_q;
    logic [15:0] drop_sum;

    always_comb begin
        drop_sum = {8'd0, drop_total_q};
        for (int i = 0; i < NLANES; i++) begin
            drop_sum = drop_sum + 16'(drop_new[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_total_q <= '0;
        end else if (drop_sum > 16'd255) begin
            drop_total_q <= 8'hFF;
        end else begin
            drop_total_q <= drop_sum[7:0];
        end
    end

    assign drop_total = drop_total_q;
`else
    assign drop_total = 8'd0;
`endif

    // ------------------------------------------------------------------
    // Structural properties
    // ------------------------------------------------------------------
    a_grant_onehot : assert property (@(posedge clk) disable iff (reset)
        grant_valid |-> $onehot(grant_oh));

    a_drop_sticky : assert property (@(posedge clk) disable iff (reset)
        (drop != '0) |=> ((drop & $past(drop)) == $past(drop)));

endmodule

// File: tb/tb_edgevec_sched.sv
// -----------------------------------------------------------------------------
// tb_edgevec_sched
//
// Testbench for edgevec_sched with NLANES=2 and CNT_W=2.
//
// The bench keeps a behavioural model of the scheduler. The model tracks:
//   - a pending bit per lane,
//   - the index of the last granted lane,
//   - plain integer counters.
// A negedge process compares every DUT output with the model on every cycle
// after the first reset. Hand-computed literal checks pin the directed
// scenarios. Randomized traffic and a saturation phase follow.
// -----------------------------------------------------------------------------
module tb_edgevec_sched;

    localparam int NL = 2;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NL-1:0]     lane_vec;
    logic [NL*CW-1:0]  count;
    logic [NL-1:0]     grant_oh;
    logic              grant_valid;
    logic [NL-1:0]     drop;
    logic [7:0]        drop_total;

    edgevec_sched #(.NLANES(NL), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .lane_vec    (lane_vec),
        .enable      (enable),
        .count       (count),
        .grant_oh    (grant_oh),
        .grant_valid (grant_valid),
        .drop        (drop),
        .drop_total  (drop_total)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int            m_cnt  [NL];
    bit            m_pend [NL];
    bit            m_prev [NL];
    bit            m_drop [NL];
    int            m_last;          // last granted lane; the next lane is first
    int            m_dtot;
    bit            m_gv;
    logic [NL-1:0] m_goh;

    task automatic model_step(input bit rst, input bit en, input logic [NL-1:0] lv);
        int sel;
        int nd;
        bit ev;
        if (rst) begin
            for (int i = 0; i < NL; i++) begin
                m_cnt[i]  = 0;
                m_pend[i] = 1'b0;
                m_drop[i] = 1'b0;
                m_prev[i] = lv[i];
            end
            m_last = NL - 1;
            m_dtot = 0;
            m_gv   = 1'b0;
            m_goh  = '0;
            return;
        end
        sel = -1;
        if (en) begin
            for (int k = 1; k <= NL; k++) begin
                if (sel < 0 && m_pend[(m_last + k) % NL]) sel = (m_last + k) % NL;
            end
        end
        nd = 0;
        for (int i = 0; i < NL; i++) begin
            ev = lv[i] && !m_prev[i];
            if (ev && m_pend[i] && i != sel) begin
                m_drop[i] = 1'b1;
                nd++;
            end
            m_pend[i] = (m_pend[i] && i != sel) || ev;
            m_prev[i] = lv[i];
        end
        if (sel >= 0) begin
            m_cnt[sel] = (m_cnt[sel] + 1) % (1 << CW);
            m_goh      = '0;
            m_goh[sel] = 1'b1;
            m_gv       = 1'b1;
            m_last     = sel;
        end else begin
            m_gv = 1'b0;
        end
`ifdef EDGEVEC_SCHED_DROPCNT_EN
        m_dtot = (m_dtot + nd > 255) ? 255 : m_dtot + nd;
`else
        m_dtot = 0;
`endif
    endtask

    function automatic logic [NL*CW-1:0] exp_count();
        logic [NL*CW-1:0] r;
        r = '0;
        for (int i = 0; i < NL; i++) r[i*CW +: CW] = CW'(m_cnt[i]);
        return r;
    endfunction

    function automatic logic [NL-1:0] exp_drop();
        logic [NL-1:0] r;
        r = '0;
        for (int i = 0; i < NL; i++) r[i] = m_drop[i];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model.count",       32'(count),       32'(exp_count()));
            check("model.grant_oh",    32'(grant_oh),    32'(m_goh));
            check("model.grant_valid", 32'(grant_valid), 32'(m_gv));
            check("model.drop",        32'(drop),        32'(exp_drop()));
            check("model.drop_total",  32'(drop_total),  32'(m_dtot));
        end
    end

    // Apply inputs, let one edge happen, then advance the model with those
    // same inputs. Returns 2 time units after the edge, when outputs have
    // settled.
    task automatic cycle(input bit rst, input bit en, input logic [NL-1:0] lv);
        reset    = rst;
        enable   = en;
        lane_vec = lv;
        @(posedge clk);
        model_step(rst, en, lv);
        if (rst) chk_on = 1'b1;
        #2;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int wrap_exp [5];
    int exp_dtot_one;
    int exp_dtot_sat;

    initial begin
        wrap_exp = '{1, 2, 3, 0, 1};
`ifdef EDGEVEC_SCHED_DROPCNT_EN
        exp_dtot_one = 1;
        exp_dtot_sat = 255;
`else
        exp_dtot_one = 0;
        exp_dtot_sat = 0;
`endif

        // Both lanes high through reset, then held: no events.
        cycle(1'b1, 1'b1, 2'b11);
        cycle(1'b1, 1'b1, 2'b11);
        check("rst.count",       32'(count),       32'h0);
        check("rst.grant_oh",    32'(grant_oh),    32'h0);
        check("rst.grant_valid", 32'(grant_valid), 32'h0);
        check("rst.drop",        32'(drop),        32'h0);
        check("rst.drop_total",  32'(drop_total),  32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 2'b11);
            check("held.grant_valid", 32'(grant_valid), 32'h0);
            check("held.count",       32'(count),       32'h0);
        end

        // Single lane 0 event: one-edge latency.
        cycle(1'b1, 1'b1, 2'b00);
        cycle(1'b0, 1'b1, 2'b01);
        check("lat.e0_valid", 32'(grant_valid), 32'h0);
        cycle(1'b0, 1'b1, 2'b01);
        check("lat.e1_count", 32'(count),       32'h1);
        check("lat.e1_oh",    32'(grant_oh),    32'h1);
        check("lat.e1_valid", 32'(grant_valid), 32'h1);
        cycle(1'b0, 1'b1, 2'b00);
        check("lat.e2_valid", 32'(grant_valid), 32'h0);
        check("lat.e2_oh",    32'(grant_oh),    32'h1);

        // Both lanes at once: lane 0 first after reset, then lane 1.
        cycle(1'b1, 1'b1, 2'b00);
        cycle(1'b0, 1'b1, 2'b11);
        cycle(1'b0, 1'b1, 2'b11);
        check("rr.first_oh", 32'(grant_oh),    32'h1);
        check("rr.first_v",  32'(grant_valid), 32'h1);
        cycle(1'b0, 1'b1, 2'b11);
        check("rr.second_oh", 32'(grant_oh),    32'h2);
        check("rr.second_v",  32'(grant_valid), 32'h1);
        check("rr.count",     32'(count),       32'h5);
        check("rr.drop",      32'(drop),        32'h0);

        // Five spaced lane 1 events: counter wraps.
        cycle(1'b1, 1'b1, 2'b00);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, 2'b10);
            cycle(1'b0, 1'b1, 2'b00);
            check("wrap.count1", 32'(count[3:2]), 32'(wrap_exp[k]));
        end

        // Two lane 0 events while disabled: the second is dropped.
        cycle(1'b1, 1'b0, 2'b00);
        cycle(1'b0, 1'b0, 2'b01);
        cycle(1'b0, 1'b0, 2'b00);
        cycle(1'b0, 1'b0, 2'b01);
        check("dis.drop",       32'(drop),        32'h1);
        check("dis.drop_total", 32'(drop_total),  32'(exp_dtot_one));
        check("dis.count",      32'(count),       32'h0);
        cycle(1'b0, 1'b1, 2'b00);
        check("dis.count_after", 32'(count[1:0]), 32'h1);

        // New lane 0 event on the edge that services lane 0.
        cycle(1'b1, 1'b0, 2'b00);
        cycle(1'b0, 1'b0, 2'b01);
        cycle(1'b0, 1'b0, 2'b00);
        cycle(1'b0, 1'b1, 2'b01);
        check("same.count_1", 32'(count[1:0]), 32'h1);
        check("same.drop_1",  32'(drop),       32'h0);
        cycle(1'b0, 1'b1, 2'b01);
        check("same.count_2", 32'(count[1:0]), 32'h2);
        check("same.drop_2",  32'(drop),       32'h0);

        // Randomized traffic with occasional resets and enable gaps.
        cycle(1'b1, 1'b1, 2'b00);
        for (int n = 0; n < 1500; n++) begin
            cycle(($urandom % 100) == 0, ($urandom % 4) != 0, NL'($urandom));
        end

        // Disabled toggling on both lanes drives drop_total into saturation.
        cycle(1'b1, 1'b0, 2'b00);
        for (int n = 0; n < 600; n++) begin
            cycle(1'b0, 1'b0, (n % 2 == 0) ? 2'b11 : 2'b00);
        end
        check("sat.drop_total", 32'(drop_total), 32'(exp_dtot_sat));
        check("sat.drop",       32'(drop),       32'h3);
        for (int n = 0; n < 4; n++) cycle(1'b0, 1'b1, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
